farm_sensor_req: RTL and testbench

Farm-road vehicle-detector front end that generates the request input `c` for the intersection light controller. It synchronizes and debounces the raw inductive-loop signal and counts waiting vehicles. Departures are retired by observing the controller's `light_farm` output. It drives the registered `car_req` level back into the controller, closing the loop between road sensor and light FSM.

---
 rtl/traffic_pkg.sv | 15 +
 rtl/loop_debounce.sv | 66 ++++++
 rtl/farm_sensor_req.sv | 98 +++++++++
 tb/tb_farm_sensor_req.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared lamp encodings and loop-debounce state type for the intersection.
package traffic_pkg;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    typedef enum logic [1:0] {
        LO     = 2'd0,
        CHK_HI = 2'd1,
        HI     = 2'd2,
        CHK_LO = 2'd3
    } deb_state_e;

endpackage

// File: rtl/loop_debounce.sv
// Two-flop synchronizer and debounce FSM for one inductive loop;
// emits one-cycle arrive_p/depart_p pulses on accepted level changes.
module loop_debounce
    import traffic_pkg::*;
#(
    parameter int DEB_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic loop_raw,
    output logic arrive_p,
    output logic depart_p
);

    localparam int DW = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

    logic          r_s1;
    logic          r_s2;
    deb_state_e    r_state;
    logic [DW-1:0] r_deb;
    logic          w_accept;

    assign w_accept = (r_deb == DEB_LAST);
    // Pulses fire in the acceptance cycle so the counter updates on the same edge as the FSM.
    assign arrive_p = (r_state == CHK_HI) && r_s2 && w_accept;
    assign depart_p = (r_state == CHK_LO) && !r_s2 && w_accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_state <= LO;
            r_deb   <= '0;
        end else begin
            r_s1 <= loop_raw;
            r_s2 <= r_s1;
            case (r_state)
                LO: begin
                    if (r_s2) begin
                        r_state <= CHK_HI;
                        r_deb   <= DW'(1);
                    end
                end
                CHK_HI: begin
                    if (!r_s2)         r_state <= LO;
                    else if (w_accept) r_state <= HI;
                    else               r_deb   <= r_deb + 1'b1;
                end
                HI: begin
                    if (!r_s2) begin
                        r_state <= CHK_LO;
                        r_deb   <= DW'(1);
                    end
                end
                CHK_LO: begin
                    if (r_s2)          r_state <= HI;
                    else if (w_accept) r_state <= LO;
                    else               r_deb   <= r_deb + 1'b1;
                end
                default: r_state <= LO;
            endcase
        end
    end

endmodule

// File: rtl/farm_sensor_req.sv
// Farm-road vehicle counter driving the controller request input c.
// Optional green-timeout yield enabled by FARM_SENSOR_TIMEOUT_EN.
module farm_sensor_req
    import traffic_pkg::*;
#(
    parameter int DEB_CYC   = 4,
    parameter int CNT_W     = 4,
    parameter int MAX_GREEN = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             loop_raw,
    input  logic [2:0]       light_farm,
    output logic             car_req,
    output logic [CNT_W-1:0] car_count,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (DEB_CYC < 2 || MAX_GREEN < 2) begin : g_bad_param
        $error("farm_sensor_req: DEB_CYC and MAX_GREEN must be >= 2");
    end

    logic             w_arrive;
    logic             w_depart;
    logic             w_green;
    logic             w_dec;
    logic             w_sat;
    logic [CNT_W-1:0] w_next_count;
    logic             w_next_req;
    logic [CNT_W-1:0] r_count;
    logic             r_req;
    logic             r_ovf;

    loop_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_deb (
        .clk      (clk),
        .rst_n    (rst_n),
        .loop_raw (loop_raw),
        .arrive_p (w_arrive),
        .depart_p (w_depart)
    );

    assign w_green = (light_farm == LAMP_GREEN);
    assign w_sat   = (r_count == CNT_MAX);
    // A vehicle leaving under red/yellow was never served, so it is not retired.
    assign w_dec   = w_depart && w_green && (r_count != '0);

    always_comb begin
        w_next_count = r_count;
        if (w_arrive && !w_sat) w_next_count = r_count + 1'b1;
        else if (w_dec)         w_next_count = r_count - 1'b1;
    end

`ifdef FARM_SENSOR_TIMEOUT_EN
    localparam int TW = $clog2(MAX_GREEN);
    localparam logic [TW-1:0] T_LAST = TW'(MAX_GREEN - 1);

    logic [TW-1:0] r_timer;
    logic          r_expired;
    logic          w_next_expired;

    assign w_next_expired = w_green && (r_expired || (r_timer == T_LAST));
    assign w_next_req     = (w_next_count != '0) && !w_next_expired;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_timer   <= '0;
            r_expired <= 1'b0;
        end else begin
            r_expired <= w_next_expired;
            if (!w_green)              r_timer <= '0;
            else if (r_timer != T_LAST) r_timer <= r_timer + 1'b1;
        end
    end
`else
    assign w_next_req = (w_next_count != '0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            r_req   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_req   <= w_next_req;
            if (w_arrive && w_sat) r_ovf <= 1'b1;
        end
    end

    assign car_count = r_count;
    assign car_req   = r_req;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_farm_sensor_req.sv
// Directed bench for farm_sensor_req (DEB_CYC=4, CNT_W=2, MAX_GREEN=8).
module tb_farm_sensor_req;
    import traffic_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       loop_raw;
    logic [2:0] light_farm;
    logic       car_req;
    logic [1:0] car_count;
    logic       overflow;

    int n_cmp;
    int n_bad;

    farm_sensor_req #(
        .DEB_CYC   (4),
        .CNT_W     (2),
        .MAX_GREEN (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .loop_raw   (loop_raw),
        .light_farm (light_farm),
        .car_req    (car_req),
        .car_count  (car_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; sample and drive 1 time unit after it.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic arrive_one();
        loop_raw = 1'b1;
        tick(8);
        loop_raw = 1'b0;
        tick(8);
    endtask

    task automatic test_reset();
        loop_raw   = 1'b0;
        light_farm = LAMP_RED;
        do_reset();
        n_cmp++;
        if (car_count !== 2'd0) begin
            n_bad++; $display("FAIL reset_count got %0d want 0", car_count);
        end
        n_cmp++;
        if (car_req !== 1'b0) begin
            n_bad++; $display("FAIL reset_req got %b want 0", car_req);
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++; $display("FAIL reset_ovf got %b want 0", overflow);
        end
    endtask

    task automatic test_single_vehicle();
        do_reset();
        light_farm = LAMP_RED;
        loop_raw   = 1'b1;
        tick(5);
        n_cmp++;
        if (car_count !== 2'd0) begin
            n_bad++; $display("FAIL arr_early got %0d want 0", car_count);
        end
        tick(1);
        n_cmp++;
        if (car_count !== 2'd1) begin
            n_bad++; $display("FAIL arr_count got %0d want 1", car_count);
        end
        n_cmp++;
        if (car_req !== 1'b1) begin
            n_bad++; $display("FAIL arr_req got %b want 1", car_req);
        end
        light_farm = LAMP_GREEN;
        loop_raw   = 1'b0;
        tick(5);
        n_cmp++;
        if (car_count !== 2'd1) begin
            n_bad++; $display("FAIL dep_early got %0d want 1", car_count);
        end
        tick(1);
        n_cmp++;
        if (car_count !== 2'd0) begin
            n_bad++; $display("FAIL dep_count got %0d want 0", car_count);
        end
        n_cmp++;
        if (car_req !== 1'b0) begin
            n_bad++; $display("FAIL dep_req got %b want 0", car_req);
        end
        light_farm = LAMP_RED;
    endtask

    task automatic test_glitch();
        do_reset();
        light_farm = LAMP_RED;
        loop_raw   = 1'b1;
        tick(3);
        loop_raw = 1'b0;
        tick(10);
        n_cmp++;
        if (car_count !== 2'd0) begin
            n_bad++; $display("FAIL glitch_count got %0d want 0", car_count);
        end
        n_cmp++;
        if (car_req !== 1'b0) begin
            n_bad++; $display("FAIL glitch_req got %b want 0", car_req);
        end
    endtask

    task automatic test_depart_red();
        do_reset();
        light_farm = LAMP_RED;
        arrive_one();
        n_cmp++;
        if (car_count !== 2'd1) begin
            n_bad++; $display("FAIL red_leave got %0d want 1", car_count);
        end
        n_cmp++;
        if (car_req !== 1'b1) begin
            n_bad++; $display("FAIL red_req got %b want 1", car_req);
        end
        light_farm = LAMP_GREEN;
        tick(10);
        n_cmp++;
        if (car_count !== 2'd1) begin
            n_bad++; $display("FAIL green_idle got %0d want 1", car_count);
        end
        light_farm = LAMP_RED;
    endtask

    task automatic test_saturation();
        do_reset();
        light_farm = LAMP_RED;
        for (int i = 0; i < 3; i++) arrive_one();
        n_cmp++;
        if (car_count !== 2'd3 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL sat3 got cnt=%0d ovf=%b want cnt=3 ovf=0", car_count, overflow);
        end
        arrive_one();
        n_cmp++;
        if (car_count !== 2'd3) begin
            n_bad++; $display("FAIL sat_hold got %0d want 3", car_count);
        end
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_bad++; $display("FAIL sat_ovf got %b want 1", overflow);
        end
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        n_cmp++;
        if (car_count !== 2'd0 || car_req !== 1'b0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_reset got cnt=%0d req=%b ovf=%b want all 0",
                     car_count, car_req, overflow);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        light_farm = LAMP_RED;
        arrive_one();
        arrive_one();
        light_farm = LAMP_GREEN;
`ifdef FARM_SENSOR_TIMEOUT_EN
        tick(7);
        n_cmp++;
        if (car_req !== 1'b1) begin
            n_bad++; $display("FAIL to_before got %b want 1", car_req);
        end
        tick(1);
        n_cmp++;
        if (car_req !== 1'b0) begin
            n_bad++; $display("FAIL to_expired got %b want 0", car_req);
        end
        n_cmp++;
        if (car_count !== 2'd2) begin
            n_bad++; $display("FAIL to_count got %0d want 2", car_count);
        end
        light_farm = LAMP_YELLOW;
        tick(1);
        n_cmp++;
        if (car_req !== 1'b1) begin
            n_bad++; $display("FAIL to_yellow got %b want 1", car_req);
        end
`else
        tick(20);
        n_cmp++;
        if (car_req !== 1'b1) begin
            n_bad++; $display("FAIL long_green_req got %b want 1", car_req);
        end
        n_cmp++;
        if (car_count !== 2'd2) begin
            n_bad++; $display("FAIL long_green_cnt got %0d want 2", car_count);
        end
`endif
        light_farm = LAMP_RED;
    endtask

    task automatic test_reset_occupied();
        do_reset();
        light_farm = LAMP_RED;
        loop_raw   = 1'b1;
        tick(8);
        n_cmp++;
        if (car_count !== 2'd1) begin
            n_bad++; $display("FAIL occ_pre got %0d want 1", car_count);
        end
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        n_cmp++;
        if (car_count !== 2'd0) begin
            n_bad++; $display("FAIL occ_reset got %0d want 0", car_count);
        end
        tick(5);
        n_cmp++;
        if (car_count !== 2'd0) begin
            n_bad++; $display("FAIL occ_early got %0d want 0", car_count);
        end
        tick(1);
        n_cmp++;
        if (car_count !== 2'd1 || car_req !== 1'b1) begin
            n_bad++;
            $display("FAIL occ_rearrive got cnt=%0d req=%b want cnt=1 req=1",
                     car_count, car_req);
        end
        loop_raw = 1'b0;
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        loop_raw   = 1'b0;
        light_farm = LAMP_RED;
        test_reset();
        test_single_vehicle();
        test_glitch();
        test_depart_red();
        test_saturation();
        test_timeout();
        test_reset_occupied();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
